// File: rtl/lfsr_datapath.sv
// lfsr_datapath
//   Small register-file + ALU datapath intended for building LFSRs and
//   similar bit-twiddling sequences out of shift/XOR micro-ops.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset
//   raddr1     read address A (ALU operand A)
//   raddr2     read address B (operand B when wdsrc=1)
//   wen        register-file write enable
//   waddr      write address
//   wdsrc      operand-B select: 0 = constant, 1 = port-B read data
//   func       ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHR, 6 SHL,
//              7 PASSB, 8 PASSA, 9-15 illegal (result 0)
//   constant   immediate operand
//   isZero     registered: last written value was zero
//   lfsr_out   contents of register 1
//   alu_y      combinational ALU result for the current inputs
//   bad_func   sticky: an illegal func was issued with wen=1
module lfsr_datapath #(
  parameter int DW   = 32,
  parameter int NREG = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    raddr1,
  input  logic [3:0]    raddr2,
  input  logic          wen,
  input  logic [3:0]    waddr,
  input  logic          wdsrc,
  input  logic [3:0]    func,
  input  logic [DW-1:0] constant,
  output logic          isZero,
  output logic [DW-1:0] lfsr_out,
  output logic [DW-1:0] alu_y,
  output logic          bad_func
);

  typedef enum logic [3:0] {
    F_ADD   = 4'd0,
    F_SUB   = 4'd1,
    F_AND   = 4'd2,
    F_OR    = 4'd3,
    F_XOR   = 4'd4,
    F_SHR   = 4'd5,
    F_SHL   = 4'd6,
    F_PASSB = 4'd7,
    F_PASSA = 4'd8
  } func_e;

  // Addresses at or above NREG read as zero and drop writes, so every
  // 4-bit code has a defined result even with a reduced register count.
  localparam logic [4:0] NREG_W = 5'(NREG);

  logic [DW-1:0] r_rf [NREG];
  logic          r_is_zero;
  logic          r_bad_func;

  logic [DW-1:0] w_rd1, w_rd2, w_opa, w_opb, w_y;
  logic [4:0]    w_shamt;
  logic          w_illegal;
  logic          w_wr_ok;

  // Asynchronous reads, no write bypass: same-cycle reads see old data.
  assign w_rd1 = ({1'b0, raddr1} < NREG_W) ? r_rf[raddr1] : '0;
  assign w_rd2 = ({1'b0, raddr2} < NREG_W) ? r_rf[raddr2] : '0;

  assign w_opa   = w_rd1;
  assign w_opb   = wdsrc ? w_rd2 : constant;
  assign w_shamt = w_opb[4:0];

  assign w_illegal = (func > F_PASSA);
  assign w_wr_ok   = ({1'b0, waddr} < NREG_W);

  always_comb begin
    w_y = '0;
    case (func)
      F_ADD:   w_y = w_opa + w_opb;
      F_SUB:   w_y = w_opa - w_opb;
      F_AND:   w_y = w_opa & w_opb;
      F_OR:    w_y = w_opa | w_opb;
      F_XOR:   w_y = w_opa ^ w_opb;
      F_SHR:   w_y = w_opa >> w_shamt;
      F_SHL:   w_y = w_opa << w_shamt;
      F_PASSB: w_y = w_opb;
      F_PASSA: w_y = w_opa;
      default: w_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
      r_is_zero  <= 1'b0;
      r_bad_func <= 1'b0;
    end else if (wen) begin
      if (w_illegal) begin
        // Illegal op is a no-write cycle: flag it, leave regs and isZero.
        r_bad_func <= 1'b1;
      end else begin
        if (w_wr_ok) r_rf[waddr] <= w_y;
        r_is_zero <= (w_y == '0);
      end
    end
  end

  assign alu_y    = w_y;
  assign lfsr_out = r_rf[1];
  assign isZero   = r_is_zero;
  assign bad_func = r_bad_func;

endmodule

// File: tb/tb_lfsr_datapath.sv
module tb_lfsr_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  raddr1, raddr2, waddr, func;
  logic        wen, wdsrc;
  logic [31:0] constant;
  logic        isZero, bad_func;
  logic [31:0] lfsr_out, alu_y;

  int checks   = 0;
  int failures = 0;

  lfsr_datapath #(.DW(32), .NREG(16)) dut (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2), .wen(wen),
    .waddr(waddr), .wdsrc(wdsrc), .func(func), .constant(constant),
    .isZero(isZero), .lfsr_out(lfsr_out), .alu_y(alu_y), .bad_func(bad_func)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  ra1, ra2;
    logic        wen;
    logic [3:0]  wa;
    logic        wds;
    logic [3:0]  fn;
    logic [31:0] k;
    logic [31:0] ey;      // expected alu_y before the edge
    logic [31:0] elfsr;   // expected lfsr_out after the edge
    logic        ez, eb;  // expected isZero / bad_func after the edge
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  logic [31:0] mreg [16];
  logic        mzero, mbad;

  function automatic vec_t mk(input logic [3:0] ra1, ra2, input logic we,
                              input logic [3:0] wa, input logic wds,
                              input logic [3:0] fn, input logic [31:0] k, ey,
                              elfsr, input logic ez, eb);
    vec_t v;
    v.ra1 = ra1; v.ra2 = ra2; v.wen = we; v.wa = wa; v.wds = wds;
    v.fn = fn; v.k = k; v.ey = ey; v.elfsr = elfsr; v.ez = ez; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] ra1, ra2, input logic we,
                       input logic [3:0] wa, input logic wds,
                       input logic [3:0] fn, input logic [31:0] k);
    raddr1 = ra1; raddr2 = ra2; wen = we; waddr = wa;
    wdsrc = wds; func = fn; constant = k;
  endtask

  // Spec-level ALU: plain arithmetic on the op name
  function automatic logic [31:0] ref_alu(input logic [3:0] fn,
                                          input logic [31:0] a, b);
    int unsigned sh;
    sh = b % 32;
    case (fn)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a / (32'd1 << sh);
      6: return a * (32'd1 << sh);
      7: return b;
      8: return a;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lfsr", lfsr_out, 32'h0);
    chk("reset_zero", {31'b0, isZero}, 32'h0);
    chk("reset_bad", {31'b0, bad_func}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    //            ra1 ra2 we wa ws fn k              ey            elfsr         z  b
    tbl.push_back(mk(0, 0, 1, 1, 0, 7, 32'hACE1,     32'hACE1,     32'hACE1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 4, 0, 5, 32'd0,        32'hACE1,     32'hACE1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 5, 0, 5, 32'd2,        32'h2B38,     32'hACE1, 0, 0));
    tbl.push_back(mk(4, 5, 1, 6, 1, 4, 32'd0,        32'h87D9,     32'hACE1, 0, 0));
    tbl.push_back(mk(6, 0, 0, 0, 0, 8, 32'd0,        32'h87D9,     32'hACE1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 3, 0, 7, 32'd0,        32'h0,        32'hACE1, 1, 0));
    tbl.push_back(mk(3, 0, 0, 3, 0, 8, 32'd0,        32'h0,        32'hACE1, 1, 0));
    tbl.push_back(mk(3, 0, 1, 3, 0, 0, 32'd1,        32'h1,        32'hACE1, 0, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0, 8, 32'd0,        32'h1,        32'hACE1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0, 7, 32'd5,        32'h5,        32'hACE1, 0, 0));
    tbl.push_back(mk(2, 0, 1, 2, 0, 0, 32'd4,        32'h9,        32'hACE1, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 8, 32'd0,        32'h9,        32'hACE1, 0, 0));
    tbl.push_back(mk(2, 0, 0, 0, 0, 1, 32'd10,       32'hFFFFFFFF, 32'hACE1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 2, 32'hFF00,     32'hAC00,     32'hACE1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 3, 32'hF0000000, 32'hF000ACE1, 32'hACE1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 6, 32'd4,        32'hACE10,    32'hACE1, 0, 0));
    tbl.push_back(mk(3, 0, 0, 0, 0, 6, 32'd31,       32'h80000000, 32'hACE1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 5, 32'h25,       32'h567,      32'hACE1, 0, 0));
    tbl.push_back(mk(2, 0, 1, 8, 0, 0, 32'hFFFFFFF9, 32'h2,        32'hACE1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 15, 32'd5,       32'h0,        32'hACE1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 7, 0, 7, 32'h1234,     32'h1234,     32'hACE1, 0, 0));
    tbl.push_back(mk(1, 0, 1, 7, 0, 12, 32'd0,       32'h0,        32'hACE1, 0, 1));
    tbl.push_back(mk(7, 0, 0, 0, 0, 8, 32'd0,        32'h1234,     32'hACE1, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 7, 32'h77,       32'h77,       32'hACE1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8, 32'd0,        32'h77,       32'hACE1, 0, 1));
    tbl.push_back(mk(0, 6, 1, 1, 1, 7, 32'd0,        32'h87D9,     32'h87D9, 0, 1));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].ra1, tbl[i].ra2, tbl[i].wen, tbl[i].wa, tbl[i].wds,
            tbl[i].fn, tbl[i].k);
      #1;
      chk($sformatf("vec%0d_alu_y", i), alu_y, tbl[i].ey);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_lfsr", i), lfsr_out, tbl[i].elfsr);
      chk($sformatf("vec%0d_zero", i), {31'b0, isZero}, {31'b0, tbl[i].ez});
      chk($sformatf("vec%0d_bad", i), {31'b0, bad_func}, {31'b0, tbl[i].eb});
    end

    // Reset in the middle of a write: the write must be dropped
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 1, 1, 0, 7, 32'hFFFF);
    @(posedge clk);
    #1;
    chk("rstmid_lfsr", lfsr_out, 32'h0);
    chk("rstmid_zero", {31'b0, isZero}, 32'h0);
    chk("rstmid_bad", {31'b0, bad_func}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(6, 0, 0, 0, 0, 8, 32'd0);
    #1;
    chk("rstmid_r6_cleared", alu_y, 32'h0);

    // Randomized run against the reference model
    for (int r = 0; r < 16; r++) mreg[r] = 32'h0;
    mzero = 1'b0;
    mbad  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  ra1, ra2, wa, fn;
      logic        we, wds, do_rst;
      logic [31:0] k, b, ey;
      ra1 = 4'($urandom_range(0, 15));
      ra2 = 4'($urandom_range(0, 15));
      wa  = ($urandom_range(0, 2) == 0) ? 4'd1 : 4'($urandom_range(0, 15));
      fn  = 4'($urandom_range(0, 8));
      we  = ($urandom_range(0, 3) != 0);
      wds = 1'($urandom_range(0, 1));
      k   = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      do_rst = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      rst = do_rst;
      drive(ra1, ra2, we, wa, wds, fn, k);
      b  = wds ? mreg[ra2] : k;
      ey = ref_alu(fn, mreg[ra1], b);
      #1;
      chk($sformatf("rnd%0d_alu_y", n), alu_y, ey);
      if (do_rst) begin
        for (int r = 0; r < 16; r++) mreg[r] = 32'h0;
        mzero = 1'b0;
        mbad  = 1'b0;
      end else if (we) begin
        mreg[wa] = ey;
        mzero = (ey == 32'h0);
      end
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_lfsr", n), lfsr_out, mreg[1]);
      chk($sformatf("rnd%0d_zero", n), {31'b0, isZero}, {31'b0, mzero});
      chk($sformatf("rnd%0d_bad", n), {31'b0, bad_func}, {31'b0, mbad});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
